// File: rtl/counter_access_arbiter_pkg.sv
// Shared types for the counter access arbiter: FSM states and op encoding.
package ctr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Per-requester op select: count burst or direct load.
  localparam logic OP_COUNT = 1'b0;
  localparam logic OP_LOAD  = 1'b1;

endpackage : ctr_arb_pkg

// File: rtl/counter_access_arbiter_if.sv
// Requester-side bus of the counter access arbiter: request/op fields in,
// grant/completion/result out.
interface counter_access_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int LEN_W   = 4,
  parameter int OWN_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       op_load;
  logic [NUM_REQ*WIDTH-1:0] op_data;
  logic [NUM_REQ*LEN_W-1:0] op_len;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       done;
  logic [WIDTH-1:0]         result;
  logic                     busy;
  logic [OWN_W-1:0]         owner;

  // Requesters drive requests and ops, observe grant and completion.
  modport master (
    output req, op_load, op_data, op_len,
    input  gnt, done, result, busy, owner
  );

  // The arbiter consumes requests and reports grant/completion.
  modport slave (
    input  req, op_load, op_data, op_len,
    output gnt, done, result, busy, owner
  );
endinterface : counter_access_arbiter_if

// File: rtl/counter_access_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    valid = 1'b0;
    idx   = ptr;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule : rr_picker

// File: rtl/smartcounter.sv
// Loadable up-counter shared by all requesters; load has priority over enable,
// increment wraps naturally at 2^WIDTH.
module smartcounter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count
);

  // Counter register: load, increment, or hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      count <= '0;
    else if (load)   count <= data_in;
    else if (enable) count <= count + 1'b1;
  end

endmodule : smartcounter

// File: rtl/counter_access_arbiter.sv
// Round-robin arbiter sharing one smartcounter between NUM_REQ requesters.
// A granted requester gets one load or a burst of LEN increments, then a done
// pulse carrying the settled counter value.
module counter_access_arbiter
  import ctr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int LEN_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  counter_access_arbiter_if.slave bus,
  output logic                 cnt_enable,
  output logic                 cnt_load,
  output logic [WIDTH-1:0]     cnt_data_in,
  input  logic [WIDTH-1:0]     cnt_count
);

  localparam int OWN_W = $clog2(NUM_REQ);

  state_t             state;
  logic [OWN_W-1:0]   ptr;
  logic [OWN_W-1:0]   owner_q;
  logic               op_load_q;
  logic [WIDTH-1:0]   data_q;
  logic [LEN_W-1:0]   rem_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic [WIDTH-1:0]   result_q;
  logic               busy_q;

  logic               pick_valid;
  logic [OWN_W-1:0]   pick_idx;
  logic               sel_load;
  logic [WIDTH-1:0]   sel_data;
  logic [LEN_W-1:0]   sel_len;
  logic [NUM_REQ-1:0] sel_onehot;
  logic [NUM_REQ-1:0] owner_onehot;
  logic [OWN_W-1:0]   ptr_next;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (OWN_W)
  ) u_picker (
    .req   (bus.req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Route the picked requester's op fields and build one-hot vectors.
  always_comb begin
    sel_load     = OP_COUNT;
    sel_data     = '0;
    sel_len      = '0;
    sel_onehot   = '0;
    owner_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == OWN_W'(i)) begin
        sel_load      = bus.op_load[i];
        sel_data      = bus.op_data[i*WIDTH +: WIDTH];
        sel_len       = bus.op_len[i*LEN_W +: LEN_W];
        sel_onehot[i] = 1'b1;
      end
      if (owner_q == OWN_W'(i)) owner_onehot[i] = 1'b1;
    end
  end

  // Pointer moves just past the owner, wrapping at NUM_REQ.
  assign ptr_next = (owner_q == OWN_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // Arbitration FSM: IDLE picks and latches, EXEC drives the counter,
  // DONE reports the result and advances the round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      owner_q   <= '0;
      op_load_q <= OP_COUNT;
      data_q    <= '0;
      rem_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      gnt_q  <= '0;
      done_q <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner_q   <= pick_idx;
            op_load_q <= sel_load;
            data_q    <= sel_data;
            rem_q     <= sel_len;
            gnt_q     <= sel_onehot;
            busy_q    <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          // A load, a zero-length burst, or the final increment ends EXEC.
          if (op_load_q == OP_LOAD || rem_q <= LEN_W'(1)) begin
            rem_q  <= '0;
            done_q <= owner_onehot;
            state  <= DONE;
          end else begin
            rem_q <= rem_q - 1'b1;
          end
        end
        DONE: begin
          result_q <= cnt_count;
          ptr      <= ptr_next;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Counter controls follow the latched op and are quiet outside EXEC.
  assign cnt_load    = (state == EXEC) && (op_load_q == OP_LOAD);
  assign cnt_enable  = (state == EXEC) && (op_load_q == OP_COUNT) && (rem_q != '0);
  assign cnt_data_in = cnt_load ? data_q : '0;

  // During DONE the counter has already settled, so pass it straight through
  // to make result valid alongside done; afterwards hold the captured copy.
  assign bus.result = (state == DONE) ? cnt_count : result_q;
  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.owner  = owner_q;

endmodule : counter_access_arbiter

// File: tb/tb_counter_access_arbiter.sv
// Bench for counter_access_arbiter driving a real smartcounter; expectations
// come from a transaction-level model (pointer + counter value).
module tb_counter_access_arbiter;
  import ctr_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int LEN_W   = 4;
  localparam int OWN_W   = $clog2(NUM_REQ);

  logic             clk = 1'b0;
  logic             reset;
  logic             cnt_enable;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_data_in;
  logic [WIDTH-1:0] cnt_count;

  int n_tests = 0;
  int n_fail  = 0;
  int model_cnt = 0;
  int model_ptr = 0;

  counter_access_arbiter_if #(
    .NUM_REQ (NUM_REQ), .WIDTH (WIDTH), .LEN_W (LEN_W), .OWN_W (OWN_W)
  ) bus ();

  counter_access_arbiter #(
    .NUM_REQ (NUM_REQ), .WIDTH (WIDTH), .LEN_W (LEN_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .cnt_enable  (cnt_enable),
    .cnt_load    (cnt_load),
    .cnt_data_in (cnt_data_in),
    .cnt_count   (cnt_count)
  );

  smartcounter #(.WIDTH (WIDTH)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .enable  (cnt_enable),
    .load    (cnt_load),
    .data_in (cnt_data_in),
    .count   (cnt_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit load, input int data, input int len);
    bus.req[i]                     = 1'b1;
    bus.op_load[i]                 = load;
    bus.op_data[i*WIDTH +: WIDTH]  = WIDTH'(data);
    bus.op_len[i*LEN_W +: LEN_W]   = LEN_W'(len);
  endtask

  task automatic set_random_req(input int i);
    set_req(i, ($urandom_range(0, 2) == 0), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 15)));
  endtask

  // Called at a negedge while the DUT is IDLE with requests stable.
  task automatic run_txn(input string tag);
    int  exp_idx, exp_data, exp_len, exp_res, exp_cyc;
    int  en_cnt, ld_cnt, waits;
    bit  exp_load;
    exp_idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int c;
      c = (model_ptr + k) % NUM_REQ;
      if (bus.req[c]) exp_idx = c;
    end
    exp_load = bus.op_load[exp_idx];
    exp_data = int'(bus.op_data[exp_idx*WIDTH +: WIDTH]);
    exp_len  = int'(bus.op_len[exp_idx*LEN_W +: LEN_W]);
    exp_res  = exp_load ? exp_data : (model_cnt + exp_len) % (1 << WIDTH);
    exp_cyc  = exp_load ? 1 : ((exp_len == 0) ? 1 : exp_len);

    @(negedge clk);
    check({tag, "/gnt"},   32'(bus.gnt),   32'(1 << exp_idx));
    check({tag, "/owner"}, 32'(bus.owner), 32'(exp_idx));
    check({tag, "/busy"},  32'(bus.busy),  32'd1);

    // Fields are don't-care after grant: scramble them to prove latching.
    bus.req[exp_idx] = 1'b0;
    bus.op_load[exp_idx] = 1'($urandom);
    bus.op_data[exp_idx*WIDTH +: WIDTH] = WIDTH'($urandom);
    bus.op_len[exp_idx*LEN_W +: LEN_W]  = LEN_W'($urandom);

    en_cnt = 0; ld_cnt = 0; waits = 0;
    while (bus.done == '0 && waits < 40) begin
      if (cnt_enable) en_cnt++;
      if (cnt_load) begin
        ld_cnt++;
        check({tag, "/data_in"}, 32'(cnt_data_in), 32'(exp_data));
      end
      @(negedge clk);
      waits++;
    end
    check({tag, "/latency"}, 32'(waits),       32'(exp_cyc));
    check({tag, "/done"},    32'(bus.done),    32'(1 << exp_idx));
    check({tag, "/result"},  32'(bus.result),  32'(exp_res));
    check({tag, "/enables"}, 32'(en_cnt),      exp_load ? 32'd0 : 32'(exp_len));
    check({tag, "/loads"},   32'(ld_cnt),      exp_load ? 32'd1 : 32'd0);

    model_cnt = exp_res;
    model_ptr = (exp_idx + 1) % NUM_REQ;

    @(negedge clk);
    check({tag, "/done_clr"}, 32'(bus.done),   32'd0);
    check({tag, "/idle"},     32'(bus.busy),   32'd0);
    check({tag, "/held"},     32'(bus.result), 32'(exp_res));
    check({tag, "/count"},    32'(cnt_count),  32'(model_cnt));
  endtask

  initial begin
    reset       = 1'b0;
    bus.req     = '1;
    bus.op_load = '1;
    bus.op_data = '1;
    bus.op_len  = '1;

    // Reset holds everything quiet even with all requests asserted.
    repeat (3) @(negedge clk);
    check("rst/gnt",     32'(bus.gnt),     32'd0);
    check("rst/done",    32'(bus.done),    32'd0);
    check("rst/busy",    32'(bus.busy),    32'd0);
    check("rst/owner",   32'(bus.owner),   32'd0);
    check("rst/result",  32'(bus.result),  32'd0);
    check("rst/cnt_en",  32'(cnt_enable),  32'd0);
    check("rst/cnt_ld",  32'(cnt_load),    32'd0);
    check("rst/cnt_din", 32'(cnt_data_in), 32'd0);
    bus.req = '0;
    reset   = 1'b1;
    @(negedge clk);

    // Single load.
    set_req(2, 1'b1, 100, 0);
    run_txn("load100");

    // Count bursts from 100.
    set_req(0, 1'b0, 0, 3);
    run_txn("cnt3");
    set_req(0, 1'b0, 0, 0);
    run_txn("cnt0");
    set_req(3, 1'b0, 0, 0);
    run_txn("align_ptr");

    // Contention: all four, then 0 and 3.
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 0, i + 1);
    for (int i = 0; i < NUM_REQ; i++) run_txn($sformatf("rr_all%0d", i));
    set_req(0, 1'b0, 0, 1);
    set_req(3, 1'b1, 7, 0);
    run_txn("rr_03a");
    run_txn("rr_03b");

    // Wrap through 2^WIDTH.
    set_req(1, 1'b1, 8'hFE, 0);
    run_txn("wrap_load");
    set_req(1, 1'b0, 0, 2);
    run_txn("wrap_cnt");

    // Reset in the third enable cycle of a 5-long burst.
    set_req(1, 1'b0, 0, 5);
    @(negedge clk);
    check("mid/gnt", 32'(bus.gnt), 32'd2);
    bus.req = '0;
    repeat (2) @(negedge clk);
    check("mid/en3", 32'(cnt_enable), 32'd1);
    reset = 1'b0;
    #1;
    check("mid/gnt0",    32'(bus.gnt),     32'd0);
    check("mid/done0",   32'(bus.done),    32'd0);
    check("mid/busy0",   32'(bus.busy),    32'd0);
    check("mid/owner0",  32'(bus.owner),   32'd0);
    check("mid/result0", 32'(bus.result),  32'd0);
    check("mid/en0",     32'(cnt_enable),  32'd0);
    check("mid/count0",  32'(cnt_count),   32'd0);
    @(negedge clk);
    check("mid/nodone",  32'(bus.done),    32'd0);
    reset = 1'b1;
    model_ptr = 0;
    model_cnt = 0;
    for (int i = 0; i < NUM_REQ; i++) set_random_req(i);
    for (int i = 0; i < NUM_REQ; i++) run_txn($sformatf("post_rst%0d", i));

    // Randomized mix against the model.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!bus.req[i] && $urandom_range(0, 1) == 1) set_random_req(i);
      if (bus.req == '0) set_random_req(int'($urandom_range(0, NUM_REQ - 1)));
      run_txn($sformatf("rand%0d", n));
    end
    for (int n = 0; n < NUM_REQ && bus.req != '0; n++)
      run_txn($sformatf("drain%0d", n));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_counter_access_arbiter
